// File: rtl/blink_arb_pkg.sv
// Shared types and default parameters for the blink arbiter.
// Optional build macro: BLINK_ARB_PRIO0_EN (fixed priority for requester 0).
package blink_arb_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int PERIOD_DEF = 4;
    localparam int BURST_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/blink_arbiter_rr_picker.sv
// Combinational round-robin selector: request vector + pointer -> one-hot grant.
// Optional build macro: BLINK_ARB_PRIO0_EN (requester 0 always wins when asserted).
module rr_picker #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int k;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        k       = 0;
`ifdef BLINK_ARB_PRIO0_EN
        if (req_i[0]) begin
            gnt_o[0] = 1'b1;
            valid_o  = 1'b1;
        end
`endif
        // Scan starting at the pointer; the first hit wins.
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr_i) + i) % N;
            if (!valid_o && req_i[k]) begin
                valid_o  = 1'b1;
                idx_o    = IW'(k);
                gnt_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/blink_arbiter.sv
// Round-robin arbiter granting a fixed-length blink burst to one requester.
// Optional build macro: BLINK_ARB_PRIO0_EN (requester 0 has fixed priority).
module blink_arbiter
    import blink_arb_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int PERIOD = PERIOD_DEF,
    parameter int BURST  = BURST_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             restart,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic             blink_out,
    output logic             done,
    output logic             aborted
);

    localparam int PW = $clog2(PERIOD);
    localparam int TW = $clog2(BURST + 1);
    localparam int IW = $clog2(N_REQ);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]    gidx_q, gidx_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             blink_q, blink_d;
    logic             aborted_q, aborted_d;

    logic [N_REQ-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic             req_g, wrap, final_wrap;

    rr_picker #(.N(N_REQ)) u_picker (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign req_g      = |(req & grant_q);
    assign wrap       = (phase_q == PW'(PERIOD - 1)) && !restart;
    assign final_wrap = wrap && (tcnt_q == TW'(BURST - 1));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        phase_d   = phase_q;
        tcnt_d    = tcnt_q;
        blink_d   = blink_q;
        aborted_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                blink_d = 1'b0;
                if (pick_valid) begin
                    grant_d = pick_gnt;
                    gidx_d  = pick_idx;
                    phase_d = '0;
                    tcnt_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // A completing burst is a normal end even if req drops now.
                if (final_wrap || !req_g) begin
                    aborted_d = !final_wrap;
                    grant_d   = '0;
                    blink_d   = 1'b0;
                    state_d   = DONE;
                end else if (restart) begin
                    phase_d = '0;
                end else if (wrap) begin
                    phase_d = '0;
                    blink_d = ~blink_q;
                    tcnt_d  = tcnt_q + TW'(1);
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            DONE: begin
                ptr_d   = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + IW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= '0;
            phase_q   <= '0;
            tcnt_q    <= '0;
            blink_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            phase_q   <= phase_d;
            tcnt_q    <= tcnt_d;
            blink_q   <= blink_d;
            aborted_q <= aborted_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = (state_q == RUN);
    assign blink_out = blink_q;
    assign done      = (state_q == DONE);
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_blink_arbiter.sv
// Directed and random checks of blink_arbiter against a cycle-count model.
// Honours BLINK_ARB_PRIO0_EN when defined for the build.
module tb_blink_arbiter;

    localparam int N      = 4;
    localparam int PERIOD = 4;
    localparam int BURST  = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] req = '0;
    logic         restart = 1'b0;
    logic [N-1:0] grant;
    logic         busy, blink_out, done, aborted;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: 0 idle, 1 run, 2 done; m_t = effective cycles into the burst.
    int m_st, m_g, m_ptr, m_t;
    bit m_ab;

    blink_arbiter #(.N_REQ(N), .PERIOD(PERIOD), .BURST(BURST)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .restart   (restart),
        .grant     (grant),
        .busy      (busy),
        .blink_out (blink_out),
        .done      (done),
        .aborted   (aborted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef BLINK_ARB_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    task automatic model_next();
        int p;
        case (m_st)
            0: begin
                p = pick(req, m_ptr);
                if (p >= 0) begin
                    m_g = p; m_t = 0; m_st = 1;
                end
            end
            1: begin
                if (!restart && m_t + 1 == BURST * PERIOD) begin
                    m_st = 2; m_ab = 1'b0;
                end else if (!req[m_g]) begin
                    m_st = 2; m_ab = 1'b1;
                end else if (restart) begin
                    m_t = (m_t / PERIOD) * PERIOD;
                end else begin
                    m_t++;
                end
            end
            default: begin
                m_ptr = (m_g + 1) % N;
                m_st  = 0;
            end
        endcase
    endtask

    task automatic check_model();
        chk("grant", 32'(grant), (m_st == 1) ? (32'd1 << m_g) : 32'd0);
        chk("busy", 32'(busy), 32'(m_st == 1));
        chk("blink", 32'(blink_out), (m_st == 1) ? 32'((m_t / PERIOD) % 2) : 32'd0);
        chk("done", 32'(done), 32'(m_st == 2));
        chk("aborted", 32'(aborted), 32'(m_st == 2 && m_ab));
    endtask

    task automatic cyc(input logic [N-1:0] r, input logic rs);
        req = r;
        restart = rs;
        model_next();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_blink", 32'(blink_out), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        m_st = 0; m_g = 0; m_ptr = 0; m_t = 0; m_ab = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = '0;
        restart = 1'b0;
    endtask

    logic [N-1:0] seq[5];

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Single requester, full burst.
        for (int e = 0; e < 10; e++) begin
            cyc(4'b0001, 1'b0);
            if (e == 0) chk("e0_grant", 32'(grant), 32'h1);
            if (e == 4) chk("e4_blink", 32'(blink_out), 32'h1);
            if (e == 8) begin
                chk("e8_done", 32'(done), 32'h1);
                chk("e8_abort", 32'(aborted), 32'h0);
                chk("e8_grant", 32'(grant), 32'h0);
            end
            if (e == 9) chk("e9_idle", 32'({busy, done}), 32'h0);
        end

        // All requesting: rotation order.
        do_reset();
`ifdef BLINK_ARB_PRIO0_EN
        seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        for (int e = 0; e < 41; e++) begin
            cyc(4'b1111, 1'b0);
            if (e % 10 == 0) chk("rr_seq", 32'(grant), 32'(seq[e / 10]));
        end

        // Restart delays the wrap.
        do_reset();
        for (int e = 0; e < 11; e++) begin
            cyc(4'b0001, e == 2);
            if (e == 5) chk("rs_blink5", 32'(blink_out), 32'h0);
            if (e == 6) chk("rs_blink6", 32'(blink_out), 32'h1);
            if (e == 9) chk("rs_done9", 32'(done), 32'h0);
            if (e == 10) chk("rs_done10", 32'(done), 32'h1);
        end

        // Request dropped mid-burst.
        do_reset();
        for (int e = 0; e < 8; e++) begin
            cyc((e < 6) ? 4'b0001 : 4'b0000, 1'b0);
            if (e == 6) begin
                chk("ab_done", 32'(done), 32'h1);
                chk("ab_abort", 32'(aborted), 32'h1);
                chk("ab_blink", 32'(blink_out), 32'h0);
            end
        end

        // Drop coincides with the final wrap.
        do_reset();
        for (int e = 0; e < 10; e++) begin
            cyc((e < 8) ? 4'b0001 : 4'b0000, 1'b0);
            if (e == 8) chk("fw_abort", 32'({done, aborted}), 32'h2);
        end

        // Two requesters.
        do_reset();
`ifdef BLINK_ARB_PRIO0_EN
        seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        seq = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
`endif
        for (int e = 0; e < 31; e++) begin
            cyc(4'b0011, 1'b0);
            if (e % 10 == 0) chk("p2_seq", 32'(grant), 32'(seq[e / 10]));
        end

        // Reset in the middle of a burst: no done pulse afterwards.
        do_reset();
        for (int e = 0; e < 6; e++) cyc(4'b0001, 1'b0);
        chk("mid_blink", 32'(blink_out), 32'h1);
        do_reset();
        cyc(4'b0000, 1'b0);
        chk("mid_nodone", 32'(done), 32'h0);

        // Random traffic.
        do_reset();
        for (int e = 0; e < 600; e++) begin
            logic [N-1:0] r;
            r = req;
            if ($urandom_range(0, 5) == 0) r = N'($urandom);
            cyc(r, $urandom_range(0, 9) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
